// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 control unit: opcodes, FSM states, adder source
// select codes and load-mask bit positions.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_ADD_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_ADD_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_IN   = 2'd2,
    SEL_ZERO = 2'd3
  } src_sel_t;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;

  function automatic logic [4:0] add5(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/td4_op_decode.sv
// Combinational TD4 opcode decoder: picks the adder source and which architectural
// register the result lands in. JNC resolves its condition from the current carry.
module td4_op_decode
  import td4_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output src_sel_t   src_sel,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic       load_pc,
  output logic       legal,
  output logic       is_jump
);

  logic [3:0] load_mask_s;

  // opcode to source/load-mask table
  always_comb begin
    src_sel     = SEL_ZERO;
    load_mask_s = 4'b0000;
    legal       = 1'b1;
    is_jump     = 1'b0;
    case (opcode)
      OP_ADD_A:  begin src_sel = SEL_A;    load_mask_s[LD_A]   = 1'b1; end
      OP_ADD_AB: begin src_sel = SEL_B;    load_mask_s[LD_A]   = 1'b1; end
      OP_IN_A:   begin src_sel = SEL_IN;   load_mask_s[LD_A]   = 1'b1; end
      OP_MOV_A:  begin src_sel = SEL_ZERO; load_mask_s[LD_A]   = 1'b1; end
      OP_ADD_BA: begin src_sel = SEL_A;    load_mask_s[LD_B]   = 1'b1; end
      OP_ADD_B:  begin src_sel = SEL_B;    load_mask_s[LD_B]   = 1'b1; end
      OP_IN_B:   begin src_sel = SEL_IN;   load_mask_s[LD_B]   = 1'b1; end
      OP_MOV_B:  begin src_sel = SEL_ZERO; load_mask_s[LD_B]   = 1'b1; end
      OP_OUT_B:  begin src_sel = SEL_B;    load_mask_s[LD_OUT] = 1'b1; end
      OP_OUT_IM: begin src_sel = SEL_ZERO; load_mask_s[LD_OUT] = 1'b1; end
      OP_JNC:    begin is_jump = 1'b1;     load_mask_s[LD_PC]  = ~carry; end
      OP_JMP:    begin is_jump = 1'b1;     load_mask_s[LD_PC]  = 1'b1; end
      default:   legal = 1'b0;
    endcase
  end

  assign load_a   = load_mask_s[LD_A];
  assign load_b   = load_mask_s[LD_B];
  assign load_out = load_mask_s[LD_OUT];
  assign load_pc  = load_mask_s[LD_PC];

endmodule

// File: rtl/td4_sequencer.sv
// TD4 multi-cycle sequencer: ROM fetch handshake with timeout, execute, register commit.
// Optional single-step input is built when TD4_STEP_EN is defined.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter int PC_W        = 4,
  parameter int ACK_TIMEOUT = 15
)
(
  input  logic            clk,
  input  logic            n_reset,
  input  logic            run,
`ifdef TD4_STEP_EN
  input  logic            step,
`endif
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [7:0]      rom_data,
  input  logic [3:0]      in_port,
  output logic [3:0]      out_port,
  output logic [PC_W-1:0] pc,
  output logic            carry,
  output logic            busy,
  output logic            illegal,
  output logic            fault
);

  state_t          state_r;
  logic [PC_W-1:0] pc_r;
  logic [3:0]      a_r;
  logic [3:0]      b_r;
  logic [3:0]      out_r;
  logic [3:0]      imm_r;
  logic            carry_r;
  logic            rom_req_r;
  logic            busy_r;
  logic            illegal_r;
  logic            fault_r;
  src_sel_t        src_sel_r;
  logic [3:0]      ld_r;
  logic            legal_r;
  logic            jump_r;
  logic [7:0]      wait_r;

  src_sel_t        src_sel_s;
  logic            load_a_s;
  logic            load_b_s;
  logic            load_out_s;
  logic            load_pc_s;
  logic            legal_s;
  logic            is_jump_s;
  logic [3:0]      src_val_s;
  logic [4:0]      sum_s;
  logic [PC_W-1:0] pc_next_s;
  logic            step_go_s;

  // Decode at capture time: carry cannot change between fetch and execute.
  td4_op_decode u_decode (
    .opcode   (rom_data[7:4]),
    .carry    (carry_r),
    .src_sel  (src_sel_s),
    .load_a   (load_a_s),
    .load_b   (load_b_s),
    .load_out (load_out_s),
    .load_pc  (load_pc_s),
    .legal    (legal_s),
    .is_jump  (is_jump_s)
  );

`ifdef TD4_STEP_EN
  logic step_d_r;

  // step history for rising-edge detection
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      step_d_r <= 1'b0;
    end else begin
      step_d_r <= step;
    end
  end

  assign step_go_s = step & ~step_d_r;
`else
  assign step_go_s = 1'b0;
`endif

  // adder operand mux, sum and next program counter
  always_comb begin
    src_val_s = 4'h0;
    case (src_sel_r)
      SEL_A:    src_val_s = a_r;
      SEL_B:    src_val_s = b_r;
      SEL_IN:   src_val_s = in_port;
      SEL_ZERO: src_val_s = 4'h0;
      default:  src_val_s = 4'h0;
    endcase
    sum_s = add5(src_val_s, imm_r);
    if (ld_r[LD_PC]) begin
      pc_next_s = PC_W'(imm_r);
    end else begin
      pc_next_s = pc_r + PC_W'(1);
    end
  end

  // control FSM, fetch handshake, timeout and architectural state
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_r   <= ST_IDLE;
      pc_r      <= '0;
      a_r       <= 4'h0;
      b_r       <= 4'h0;
      out_r     <= 4'h0;
      imm_r     <= 4'h0;
      carry_r   <= 1'b0;
      rom_req_r <= 1'b0;
      busy_r    <= 1'b0;
      illegal_r <= 1'b0;
      fault_r   <= 1'b0;
      src_sel_r <= SEL_ZERO;
      ld_r      <= 4'b0000;
      legal_r   <= 1'b0;
      jump_r    <= 1'b0;
      wait_r    <= 8'd0;
    end else begin
      illegal_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (run || step_go_s) begin
            state_r   <= ST_FETCH;
            rom_req_r <= 1'b1;
            busy_r    <= 1'b1;
            wait_r    <= 8'd0;
          end
        end
        ST_FETCH: begin
          if (rom_ack) begin
            state_r      <= ST_EXEC;
            rom_req_r    <= 1'b0;
            imm_r        <= rom_data[3:0];
            src_sel_r    <= src_sel_s;
            ld_r[LD_A]   <= load_a_s;
            ld_r[LD_B]   <= load_b_s;
            ld_r[LD_OUT] <= load_out_s;
            ld_r[LD_PC]  <= load_pc_s;
            legal_r      <= legal_s;
            jump_r       <= is_jump_s;
            illegal_r    <= ~legal_s;
          end else if (wait_r == 8'(ACK_TIMEOUT - 1)) begin
            state_r   <= ST_FAULT;
            rom_req_r <= 1'b0;
            busy_r    <= 1'b0;
            fault_r   <= 1'b1;
          end else begin
            wait_r <= wait_r + 8'd1;
          end
        end
        ST_EXEC: begin
          if (ld_r[LD_A])   a_r   <= sum_s[3:0];
          if (ld_r[LD_B])   b_r   <= sum_s[3:0];
          if (ld_r[LD_OUT]) out_r <= sum_s[3:0];
          pc_r    <= pc_next_s;
          carry_r <= (legal_r && !jump_r) ? sum_s[4] : 1'b0;
          if (run) begin
            state_r   <= ST_FETCH;
            rom_req_r <= 1'b1;
            wait_r    <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_FAULT: begin
          state_r <= ST_FAULT;
        end
        default: begin
          state_r   <= ST_IDLE;
          rom_req_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign rom_req  = rom_req_r;
  assign rom_addr = pc_r;
  assign out_port = out_r;
  assign pc       = pc_r;
  assign carry    = carry_r;
  assign busy     = busy_r;
  assign illegal  = illegal_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: a ROM responder with per-address ack delay,
// expected commits queued by the stimulus and checked by an independent monitor.
module tb_td4_sequencer;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       rom_req;
  logic [3:0] rom_addr;
  logic       rom_ack;
  logic [7:0] rom_data;
  logic [3:0] in_port = 4'h9;
  logic [3:0] out_port;
  logic [3:0] pc;
  logic       carry;
  logic       busy;
  logic       illegal;
  logic       fault;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [16];
  int         delay_tab [16];
  logic       ack_en = 1'b1;
  int         req_cnt = 0;
  int         cyc = 0;
  int         last_ack = 0;
  int         ack_gap = 0;
  logic       ack_d1 = 1'b0;
  logic       ack_d2 = 1'b0;

  typedef struct {
    logic [3:0] pc;
    logic [3:0] out;
    logic       c;
    logic       il;
    int         gap;
  } exp_t;

  exp_t q[$];

  td4_sequencer #(.PC_W(4), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .run      (run),
`ifdef TD4_STEP_EN
    .step     (step),
`endif
    .rom_req  (rom_req),
    .rom_addr (rom_addr),
    .rom_ack  (rom_ack),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .pc       (pc),
    .carry    (carry),
    .busy     (busy),
    .illegal  (illegal),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] p, input logic [3:0] o, input logic c,
                      input logic il, input int g);
    exp_t e;
    e.pc = p; e.out = o; e.c = c; e.il = il; e.gap = g;
    q.push_back(e);
  endtask

  // ROM model: acks once the request has waited delay_tab[addr] cycles
  always_comb begin
    rom_data = mem[rom_addr];
    rom_ack  = 1'b0;
    if (rom_req && ack_en && (req_cnt >= delay_tab[rom_addr])) rom_ack = 1'b1;
  end

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      req_cnt <= 0;
      ack_d1  <= 1'b0;
      ack_d2  <= 1'b0;
    end else begin
      cyc     <= cyc + 1;
      req_cnt <= (rom_req && !rom_ack) ? req_cnt + 1 : 0;
      ack_d1  <= rom_req && rom_ack;
      ack_d2  <= ack_d1;
      if (rom_req && rom_ack) begin
        ack_gap  <= cyc - last_ack;
        last_ack <= cyc;
      end
    end
  end

  // monitor: EXEC cycle checks illegal/timing, the following cycle checks the commit
  always @(negedge clk) begin
    exp_t e;
    if (n_reset && ack_d1) begin
      check("exec_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        check("illegal_in_exec", 32'(illegal), 32'(q[0].il));
        if (q[0].gap != 0) check("ack_gap", 32'(ack_gap), 32'(q[0].gap));
      end
    end
    if (n_reset && ack_d2) begin
      check("commit_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc", 32'(pc), 32'(e.pc));
        check("out_port", 32'(out_port), 32'(e.out));
        check("carry", 32'(carry), 32'(e.c));
        check("illegal_pulse_end", 32'(illegal), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) delay_tab[i] = 0;
    delay_tab[15] = 3;
    mem[0]  = 8'h35; mem[1]  = 8'h0C; mem[2]  = 8'h40; mem[3]  = 8'h90;
    mem[4]  = 8'h3F; mem[5]  = 8'h01; mem[6]  = 8'hE7; mem[7]  = 8'hE9;
    mem[8]  = 8'h00; mem[9]  = 8'h80; mem[10] = 8'h76; mem[11] = 8'hB3;
    mem[12] = 8'h1F; mem[13] = 8'hA0; mem[14] = 8'h29; mem[15] = 8'h91;

    repeat (3) @(negedge clk);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_out", 32'(out_port), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    n_reset = 1'b1;

    // pc_after, out, carry, illegal, ack gap (0 = not checked)
    push(4'd1,  4'h0, 1'b0, 1'b0, 0);
    push(4'd2,  4'h0, 1'b1, 1'b0, 2);
    push(4'd3,  4'h0, 1'b0, 1'b0, 2);
    push(4'd4,  4'h1, 1'b0, 1'b0, 2);
    push(4'd5,  4'h1, 1'b0, 1'b0, 2);
    push(4'd6,  4'h1, 1'b1, 1'b0, 2);
    push(4'd7,  4'h1, 1'b0, 1'b0, 2);
    push(4'd9,  4'h1, 1'b0, 1'b0, 2);
    push(4'd10, 4'h1, 1'b0, 1'b1, 2);
    push(4'd11, 4'h1, 1'b0, 1'b0, 2);
    push(4'd12, 4'h3, 1'b0, 1'b0, 2);
    push(4'd13, 4'h3, 1'b1, 1'b0, 2);
    push(4'd14, 4'h3, 1'b0, 1'b1, 2);
    push(4'd15, 4'h3, 1'b1, 1'b0, 2);
    push(4'd0,  4'h7, 1'b0, 1'b0, 5);

    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 200 && !(rom_req && rom_addr == 4'd15); i++) @(negedge clk);
    check("reach_addr15", 32'(rom_req && rom_addr == 4'd15), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
    check("drain_run", 32'(q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_req", 32'(rom_req), 32'd0);
    check("stop_pc", 32'(pc), 32'd0);

    // reset while a fetch is outstanding
    ack_en = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("midfetch_req", 32'(rom_req), 32'd1);
    check("midfetch_busy", 32'(busy), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    check("async_req", 32'(rom_req), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_out", 32'(out_port), 32'd0);
    check("async_pc", 32'(pc), 32'd0);
    run = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;

    // fetch timeout
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 10 && !rom_req; i++) @(negedge clk);
    check("to_fetch_start", 32'(rom_req), 32'd1);
    repeat (14) @(negedge clk);
    check("to_cycle15_fault", 32'(fault), 32'd0);
    check("to_cycle15_req", 32'(rom_req), 32'd1);
    @(negedge clk);
    check("to_cycle16_fault", 32'(fault), 32'd1);
    check("to_cycle16_req", 32'(rom_req), 32'd0);
    check("to_cycle16_busy", 32'(busy), 32'd0);
    check("to_pc", 32'(pc), 32'd0);
    ack_en = 1'b1;
    run = 1'b0;
    repeat (3) @(negedge clk);
    run = 1'b1;
    repeat (5) @(negedge clk);
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_no_req", 32'(rom_req), 32'd0);
    run = 1'b0;

`ifdef TD4_STEP_EN
    n_reset = 1'b0;
    mem[0] = 8'h76;
    mem[1] = 8'h90;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    push(4'd1, 4'h0, 1'b0, 1'b0, 0);
    push(4'd2, 4'h6, 1'b0, 1'b0, 0);
    @(negedge clk);
    step = 1'b1;
    repeat (8) @(negedge clk);
    check("step1_pc", 32'(pc), 32'd1);
    check("step1_busy", 32'(busy), 32'd0);
    step = 1'b0;
    @(negedge clk);
    step = 1'b1;
    repeat (6) @(negedge clk);
    check("step2_drain", 32'(q.size()), 32'd0);
    check("step2_out", 32'(out_port), 32'd6);
    check("step2_busy", 32'(busy), 32'd0);
    step = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
